// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences 32-bit instruction fetches and 1/2/4-byte load/store
// accesses onto a single byte-wide RAM port. LS has fixed priority over IF.
// Words are assembled little-endian, and an in-flight fetch is dropped on a
// branch redirect.
module mem_arbiter #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active low
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   input  logic              ex_if_pce,
   output logic              if_ok,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [31:0]       ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_ok,
   output logic [31:0]       ls_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   input  logic [7:0]        ram_din
);

   typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;        // cycles spent in the access state
   logic [2:0]          last_q, last_d;      // byte count minus one
   logic                own_ls_q, own_ls_d;  // access belongs to LS
   logic                we_q, we_d;
   logic [23:0]         wdata_q, wdata_d;    // store bytes still to issue, lowest first
   logic [31:0]         buf_q, buf_d;        // assembled read word
   logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
   logic [7:0]          ram_dout_q, ram_dout_d;
   logic                ram_wr_q, ram_wr_d;
   logic [31:0]         if_data_q, if_data_d;
   logic [31:0]         ls_rdata_q, ls_rdata_d;
   logic [1:0]          rd_lane;

   // Only the low ADDR_W address bits reach the RAM; the rest are ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{if_addr[31:ADDR_W], ls_addr[31:ADDR_W]};

   // Byte captured this cycle belongs to the address driven one cycle earlier.
   assign rd_lane = cnt_q[1:0] - 2'd1;

   // State register and datapath registers; reset discards any in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= '0;
         own_ls_q   <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         buf_q      <= '0;
         ram_a_q    <= '0;
         ram_dout_q <= '0;
         ram_wr_q   <= 1'b0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         own_ls_q   <= own_ls_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         ram_a_q    <= ram_a_d;
         ram_dout_q <= ram_dout_d;
         ram_wr_q   <= ram_wr_d;
         if_data_q  <= if_data_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   // Next-state logic: grant, byte sequencing, completion and redirect abort.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      own_ls_d   = own_ls_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      ram_a_d    = ram_a_q;
      ram_dout_d = ram_dout_q;
      ram_wr_d   = ram_wr_q;
      if_data_d  = if_data_q;
      ls_rdata_d = ls_rdata_q;
      if_ok      = 1'b0;
      ls_ok      = 1'b0;

      case (state_q)
         IDLE: begin
            if (ls_req) begin
               own_ls_d = 1'b1;
               we_d     = ls_we;
               last_d   = (ls_size == 2'd0) ? 3'd0 : (ls_size == 2'd1) ? 3'd1 : 3'd3;
               ram_a_d  = ls_addr[ADDR_W-1:0];
               cnt_d    = '0;
               buf_d    = '0;
               wdata_d  = ls_wdata[31:8];
               if (ls_we) begin
                  ram_dout_d = ls_wdata[7:0];
                  ram_wr_d   = 1'b1;
                  state_d    = LS_WR;
               end else begin
                  state_d    = LS_RD;
               end
            end else if (if_req) begin
               // A redirect coinciding with the grant does not block it.
               own_ls_d = 1'b0;
               we_d     = 1'b0;
               last_d   = 3'd3;
               ram_a_d  = if_addr[ADDR_W-1:0];
               cnt_d    = '0;
               buf_d    = '0;
               state_d  = IF_RD;
            end
         end

         IF_RD, LS_RD: begin
            if (state_q == IF_RD && ex_if_pce) begin
               state_d = IDLE;
            end else begin
               if (cnt_q != 3'd0)
                  buf_d[{rd_lane, 3'b000} +: 8] = ram_din;
               if (cnt_q < last_q)
                  ram_a_d = ram_a_q + ADDR_W'(1);
               if (cnt_q == last_q + 3'd1)
                  state_d = DONE;
               cnt_d = cnt_q + 3'd1;
            end
         end

         LS_WR: begin
            if (cnt_q == last_q) begin
               ram_wr_d = 1'b0;
               state_d  = DONE;
            end else begin
               cnt_d      = cnt_q + 3'd1;
               ram_a_d    = ram_a_q + ADDR_W'(1);
               ram_dout_d = wdata_q[7:0];
               wdata_d    = {8'h00, wdata_q[23:8]};
            end
         end

         DONE: begin
            state_d = IDLE;
            if (own_ls_q) begin
               ls_ok = 1'b1;
               if (!we_q)
                  ls_rdata_d = buf_q;
            end else if (!ex_if_pce) begin
               if_ok     = 1'b1;
               if_data_d = buf_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Data outputs show the new word during the ok cycle, then hold it.
   assign if_data  = if_ok ? buf_q : if_data_q;
   assign ls_rdata = (ls_ok && !we_q) ? buf_q : ls_rdata_q;
   assign busy     = (state_q != IDLE);
   assign ram_a    = ram_a_q;
   assign ram_dout = ram_dout_q;
   assign ram_wr   = ram_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0, ex_if_pce = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
   logic [1:0]  ls_size = '0;
   logic        if_ok, ls_ok, busy, ram_wr;
   logic [31:0] if_data, ls_rdata;
   logic [16:0] ram_a;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din = '0;

   mem_arbiter #(.ADDR_W(17)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .ex_if_pce(ex_if_pce),
      .if_ok(if_ok), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_ok(ls_ok), .ls_rdata(ls_rdata),
      .busy(busy), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
      .ram_din(ram_din)
   );

   always #5 clk = ~clk;

   // Byte RAM with one-cycle read latency.
   logic [7:0] mem [0:131071];
   always @(posedge clk) begin
      if (ram_wr) mem[ram_a] <= ram_dout;
      ram_din <= mem[ram_a];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int wr_cnt = 0;
   always @(negedge clk) if (ram_wr) wr_cnt <= wr_cnt + 1;

   typedef struct { logic [31:0] data; int cyc; bit chk_data; } exp_t;
   exp_t ifq[$];
   exp_t lsq[$];

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: every ok pulse pops one expectation and checks data and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (if_ok) begin
         if (ifq.size() == 0) chk("if_ok_spurious", {31'b0, if_ok}, 32'd0);
         else begin
            e = ifq.pop_front();
            chk("if_data", if_data, e.data);
            chk("if_ok_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (ls_ok) begin
         if (lsq.size() == 0) chk("ls_ok_spurious", {31'b0, ls_ok}, 32'd0);
         else begin
            e = lsq.pop_front();
            if (e.chk_data) chk("ls_rdata", ls_rdata, e.data);
            chk("ls_ok_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic wait_ok(input bit ls);
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (ls ? ls_ok : if_ok) return;
      end
      n_tot++;
      $display("FAIL %s_timeout: got no ok, required ok within 40 cycles", ls ? "ls" : "if");
   endtask

   // Called #1 after a rising edge; ok expected lat cycles after that cycle.
   task automatic do_if(input logic [31:0] a, input logic [31:0] d, input int lat);
      exp_t e;
      if_req = 1'b1; if_addr = a;
      e.data = d; e.cyc = cyc + lat; e.chk_data = 1'b1;
      ifq.push_back(e);
      wait_ok(1'b0);
      @(posedge clk); #1 if_req = 1'b0;
   endtask

   task automatic do_ls(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] d, input int lat);
      exp_t e;
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
      e.data = d; e.cyc = cyc + lat; e.chk_data = !we;
      lsq.push_back(e);
      wait_ok(1'b1);
      @(posedge clk); #1 ls_req = 1'b0;
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h93; mem[4] = 8'h6F;
      mem['h100] = 8'h11; mem['h101] = 8'h22; mem['h102] = 8'h33; mem['h103] = 8'h44;
      mem['h22] = 8'h55;
      mem['h1FFFE] = 8'hAB; mem['h1FFFF] = 8'h7F;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ram_a", {15'b0, ram_a}, 32'd0);
      chk("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
      chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // plain fetch and a misaligned fetch
      do_if(32'h0, 32'h93000013, 6);
      do_if(32'h1, 32'h6F930000, 6);

      // simultaneous requests: LS first, IF granted after one IDLE cycle
      fork
         do_ls(1'b0, 2'd2, 32'h100, 32'h0, 32'h44332211, 6);
         do_if(32'h0, 32'h93000013, 13);
      join

      // half store
      w0 = wr_cnt;
      do_ls(1'b1, 2'd1, 32'h20, 32'hAABBCCDD, 32'h0, 3);
      chk("st_half_wr_cycles", 32'(wr_cnt - w0), 32'd2);
      chk("st_half_b0", {24'b0, mem['h20]}, 32'hDD);
      chk("st_half_b1", {24'b0, mem['h21]}, 32'hCC);
      chk("st_half_b2_untouched", {24'b0, mem['h22]}, 32'h55);

      // byte load at top of memory, then a word load that wraps
      do_ls(1'b0, 2'd0, 32'h1FFFF, 32'h0, 32'h0000007F, 3);
      do_ls(1'b0, 2'd3, 32'h0001FFFE, 32'h0, 32'h00137FAB, 6);
      chk("ls_rdata_hold", ls_rdata, 32'h00137FAB);

      // redirect in cycle 3 of a fetch
      if_req = 1'b1; if_addr = 32'h100;
      repeat (3) @(posedge clk);
      #1 ex_if_pce = 1'b1; if_req = 1'b0;
      @(posedge clk); #1 ex_if_pce = 1'b0;
      @(negedge clk);
      chk("redir_idle", {31'b0, busy}, 32'd0);
      chk("redir_if_data_kept", if_data, 32'h93000013);
      repeat (8) @(posedge clk);
      #1;

      // redirect in the DONE cycle of a fetch
      if_req = 1'b1; if_addr = 32'h100;
      repeat (6) @(posedge clk);
      #1 ex_if_pce = 1'b1;
      @(negedge clk);
      chk("redir_done_no_ok", {31'b0, if_ok}, 32'd0);
      chk("redir_done_data_kept", if_data, 32'h93000013);
      @(posedge clk); #1 ex_if_pce = 1'b0; if_req = 1'b0;
      @(negedge clk);
      chk("redir_done_idle", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      do_if(32'h100, 32'h44332211, 6);

      // redirect has no effect on LS
      ex_if_pce = 1'b1;
      do_ls(1'b0, 2'd1, 32'h100, 32'h0, 32'h00002211, 4);
      ex_if_pce = 1'b0;

      // reset in the middle of a word store, after byte 1 was written
      ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h40; ls_wdata = 32'h01020304;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; ls_req = 1'b0;
      #1;
      chk("rst_mid_ram_wr", {31'b0, ram_wr}, 32'd0);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_ram_a", {15'b0, ram_a}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_rel_idle", {31'b0, busy}, 32'd0);
      chk("rst_mid_b0", {24'b0, mem['h40]}, 32'h04);
      chk("rst_mid_b1", {24'b0, mem['h41]}, 32'h03);
      chk("rst_mid_b2", {24'b0, mem['h42]}, 32'h00);
      chk("rst_mid_b3", {24'b0, mem['h43]}, 32'h00);
      do_ls(1'b0, 2'd2, 32'h40, 32'h0, 32'h00000304, 6);

      repeat (4) @(posedge clk);
      chk("ifq_left", 32'(ifq.size()), 32'd0);
      chk("lsq_left", 32'(lsq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
